operand_fetch: RTL and testbench
================================

# operand_fetch

Little-endian operand reader for the 65C02 core. On a start request it reads 0, 1 or 2 operand bytes from memory at consecutive addresses beginning at the supplied program counter. It assembles them into a 16-bit operand, returns the advanced program counter, and pulses done. It sits between the decode stage and the 8-bit memory bus, and is the read-side counterpart of the core's CE-loaded 8-bit registers.

## Interface
- ADDR_W, 16, address and PC width
- DATA_W, 8, memory data width
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable; when 0 every register, including outputs, holds
- START  in  1  request, sampled only in IDLE with CE=1
- NBYTES  in  2  operand length: 0, 1, 2; value 3 is treated as 2
- PC_IN  in  ADDR_W  address of first operand byte, sampled with START
- DIN  in  DATA_W  memory read data, valid the CE-cycle after RD=1
- ADDR  out  ADDR_W  registered memory address
- RD  out  1  registered read strobe
- BUSY  out  1  high from the accepting edge until DONE
- DONE  out  1  one CE-cycle pulse; OPERAND and PC_OUT are valid with it
- OPERAND  out  16  {hi, lo}; unfetched bytes are 0x00
- PC_OUT  out  ADDR_W  PC_IN + NBYTES, modulo 2^ADDR_W

## Operation
- States: IDLE, RD_LO, RD_HI, DRAIN, FIN.
- IDLE, START=1, NBYTES=0:
  - go to FIN
  - OPERAND=0x0000, PC_OUT=PC_IN
- IDLE, START=1, NBYTES>=1:
  - latch PC_IN and the length
  - ADDR=PC_IN, RD=1, go to RD_LO
- RD_LO:
  - 2 bytes: ADDR=PC+1 (wraps 0xFFFF→0x0000), RD=1, go to RD_HI
  - 1 byte: RD=0, go to DRAIN
- RD_HI:
  - capture DIN into OPERAND[7:0]
  - RD=0, go to DRAIN
- DRAIN:
  - capture DIN into OPERAND[7:0] for a 1-byte operand, or OPERAND[15:8] for a 2-byte operand
  - DONE=1, PC_OUT=PC+length, go to FIN
- FIN:
  - DONE=0, BUSY=0, go to IDLE
  - OPERAND and PC_OUT hold until the next accepted START
- START while BUSY=1 is ignored, not queued.
- ADDR holds its last value when RD=0.
- All transitions and captures require CE=1. With CE=0 the block is frozen, DONE stays high if it was high, and DIN is not sampled.

## Timing
- Edge E0 is the CE=1 edge that samples START.
- 0 bytes: DONE is high after E0, for one CE-cycle.
- 1 byte:
  - RD=1 after E0
  - low byte captured at E2, DONE high after E2
- 2 bytes:
  - RD=1 after E0 (ADDR=PC) and after E1 (ADDR=PC+1)
  - low byte captured at E2, high byte captured at E3
  - DONE high after E3
- BUSY rises after E0 and falls at the same edge DONE falls. Zero-length requests pulse BUSY together with DONE.
- A new START is accepted at the earliest at the edge after DONE falls, i.e. one idle cycle between operations.
- Reset, taking effect at any edge regardless of CE:
  - state = IDLE
  - ADDR=0, RD=0, BUSY=0, DONE=0, OPERAND=0, PC_OUT=0
  - any partial fetch is discarded

## Structure
- A shared 65C02 package holds:
  - the state encoding (3-bit localparams)
  - NBYTES constants (OPLEN_0, OPLEN_1, OPLEN_2)
  - ADDR_W/DATA_W defaults
- Single module: one registered FSM plus the PC/operand datapath, about 150–200 lines. No sub-module is needed.
- If control is split out, the natural sub-module is `operand_fetch_fsm`, holding state, RD and the capture selects.

## Test plan
- Reset, then NBYTES=2, PC_IN=0x1234, memory [0x1234]=0xCD, [0x1235]=0xAB. Required: ADDR 0x1234 then 0x1235 with RD=1; DONE after E3 with OPERAND=0xABCD, PC_OUT=0x1236.
- NBYTES=1, PC_IN=0x00FF, [0x00FF]=0x5A. Required: DONE after E2, OPERAND=0x005A, PC_OUT=0x0100, a single RD cycle.
- NBYTES=2, PC_IN=0xFFFF, [0xFFFF]=0x11, [0x0000]=0x22. Required: second ADDR=0x0000, OPERAND=0x2211, PC_OUT=0x0001.
- NBYTES=0 with START. Required: DONE after E0, OPERAND=0, PC_OUT=PC_IN, RD never asserted. A second START while BUSY is ignored.
- 2-byte fetch with CE toggling every cycle, as the core clocks it. Required: same result as the first scenario, each step delayed to the next CE=1 edge, DONE held through CE=0 cycles.
- Assert RST during RD_HI. Required: all outputs 0 at the next edge. A following 1-byte fetch of 0x77 yields OPERAND=0x0077, with no stale high byte.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared 65C02 definitions used by the operand fetch path: bus widths,
// the fetch FSM state encoding and operand length codes.
package operand_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_LO = 3'd1;
  localparam logic [2:0] ST_RD_HI = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [1:0] OPLEN_0 = 2'd0;
  localparam logic [1:0] OPLEN_1 = 2'd1;
  localparam logic [1:0] OPLEN_2 = 2'd2;

  // A length code of 3 has no meaning on this core and is fetched as 2 bytes.
  function automatic logic [1:0] norm_len(input logic [1:0] n);
    return (n == 2'd3) ? OPLEN_2 : n;
  endfunction

endpackage

// File: rtl/operand_fetch.sv
// Little-endian 0/1/2-byte operand reader between decode and the 8-bit bus.
// Every register, outputs included, advances only on CE=1 edges.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CE,
  input  logic                START,
  input  logic [1:0]          NBYTES,
  input  logic [ADDR_W-1:0]   PC_IN,
  input  logic [DATA_W-1:0]   DIN,
  output logic [ADDR_W-1:0]   ADDR,
  output logic                RD,
  output logic                BUSY,
  output logic                DONE,
  output logic [2*DATA_W-1:0] OPERAND,
  output logic [ADDR_W-1:0]   PC_OUT
);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [1:0]          len_q, len_d;
  logic [1:0]          len_in;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [2*DATA_W-1:0] op_q, op_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;

  assign len_in = norm_len(NBYTES);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (START) state_d = (len_in == OPLEN_0) ? ST_FIN : ST_RD_LO;
      ST_RD_LO: state_d = (len_q == OPLEN_2) ? ST_RD_HI : ST_DRAIN;
      ST_RD_HI: state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the bus strobe and datapath registers; the operand is
  // cleared on acceptance so bytes that are not fetched read back as zero.
  always_comb begin
    pc_d     = pc_q;
    len_d    = len_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    op_d     = op_q;
    pc_out_d = pc_out_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_d = '0;
          if (len_in == OPLEN_0) begin
            pc_out_d = PC_IN;
          end else begin
            pc_d   = PC_IN;
            len_d  = len_in;
            addr_d = PC_IN;
            rd_d   = 1'b1;
          end
        end
      end
      ST_RD_LO: begin
        if (len_q == OPLEN_2) begin
          addr_d = pc_q + ADDR_W'(1);
          rd_d   = 1'b1;
        end else begin
          rd_d = 1'b0;
        end
      end
      ST_RD_HI: begin
        op_d[DATA_W-1:0] = DIN;
        rd_d             = 1'b0;
      end
      ST_DRAIN: begin
        if (len_q == OPLEN_2) op_d[2*DATA_W-1:DATA_W] = DIN;
        else                  op_d[DATA_W-1:0]        = DIN;
        pc_out_d = pc_q + ADDR_W'(len_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q   <= '0;
      rd_q     <= 1'b0;
      op_q     <= '0;
      pc_out_q <= '0;
    end else if (CE) begin
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      op_q     <= op_d;
      pc_out_q <= pc_out_d;
    end
  end

  // Fetch context only matters between acceptance and DRAIN, so no reset.
  always_ff @(posedge CLK) begin
    if (CE) begin
      pc_q  <= pc_d;
      len_q <= len_d;
    end
  end

  assign ADDR    = addr_q;
  assign RD      = rd_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = (state_q == ST_FIN);
  assign OPERAND = op_q;
  assign PC_OUT  = pc_out_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a byte-array memory answering RD one CE-cycle
// later, and a reference model working from whole-request arithmetic.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  NBYTES = 2'd0;
  logic [15:0] PC_IN = 16'h0000;
  logic [7:0]  DIN = 8'h00;
  logic [15:0] ADDR;
  logic        RD;
  logic        BUSY;
  logic        DONE;
  logic [15:0] OPERAND;
  logic [15:0] PC_OUT;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:65535];

  operand_fetch #(.ADDR_W(16), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .START(START), .NBYTES(NBYTES),
    .PC_IN(PC_IN), .DIN(DIN), .ADDR(ADDR), .RD(RD), .BUSY(BUSY),
    .DONE(DONE), .OPERAND(OPERAND), .PC_OUT(PC_OUT)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: data for a RD=1 edge appears for the next CE-cycle;
  // otherwise the bus carries junk.
  always @(posedge CLK) begin
    if (CE) DIN <= RD ? mem[ADDR] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, {16'h0, ADDR}, 32'h0);
    check({tag, "_rd"}, {31'h0, RD}, 32'h0);
    check({tag, "_busy"}, {31'h0, BUSY}, 32'h0);
    check({tag, "_done"}, {31'h0, DONE}, 32'h0);
    check({tag, "_operand"}, {16'h0, OPERAND}, 32'h0);
    check({tag, "_pc_out"}, {16'h0, PC_OUT}, 32'h0);
  endtask

  // One complete request. The model: n bytes read at pc, pc+1 (wrapping),
  // operand {byte1 or 0, byte0 or 0}, pc_out = pc+n, DONE on CE-edge n+1
  // after acceptance (edge 0 for an empty operand).
  task automatic run_fetch(input logic [15:0] pc, input logic [1:0] nb, input bit ce_toggle);
    int          n_eff;
    int          ce_edges;
    int          guard;
    logic [15:0] rd_addrs [$];
    logic [15:0] exp_op;
    logic [15:0] exp_pc;
    logic [15:0] a;
    n_eff  = (nb == 2'd3) ? 2 : int'(nb);
    a      = pc + 16'd1;
    exp_op = {(n_eff >= 2) ? mem[a] : 8'h00, (n_eff >= 1) ? mem[pc] : 8'h00};
    exp_pc = pc + 16'(n_eff);

    @(negedge CLK);
    CE = 1'b1; START = 1'b1; NBYTES = nb; PC_IN = pc;
    @(posedge CLK); #1;
    check("busy_after_accept", {31'h0, BUSY}, 32'h1);
    if (RD === 1'b1) rd_addrs.push_back(ADDR);
    ce_edges = 0;
    guard = 0;
    while (DONE !== 1'b1 && guard < 40) begin
      @(negedge CLK);
      CE = ce_toggle ? ~CE : 1'b1;
      START = 1'($urandom); NBYTES = 2'($urandom); PC_IN = 16'($urandom);
      @(posedge CLK); #1;
      if (CE) begin
        ce_edges++;
        if (RD === 1'b1 && DONE !== 1'b1) rd_addrs.push_back(ADDR);
      end
      guard++;
    end
    check("done_seen", {31'h0, DONE}, 32'h1);
    check("done_latency", 32'(ce_edges), 32'(n_eff == 0 ? 0 : n_eff + 1));
    check("operand", {16'h0, OPERAND}, {16'h0, exp_op});
    check("pc_out", {16'h0, PC_OUT}, {16'h0, exp_pc});
    check("rd_cycles", 32'(rd_addrs.size()), 32'(n_eff));
    if (rd_addrs.size() == n_eff) begin
      foreach (rd_addrs[i]) check("rd_addr", {16'h0, rd_addrs[i]}, {16'h0, pc + 16'(i)});
    end

    if (ce_toggle) begin
      @(negedge CLK);
      CE = 1'b0; START = 1'($urandom);
      @(posedge CLK); #1;
      check("done_held_ce0", {31'h0, DONE}, 32'h1);
    end
    @(negedge CLK);
    CE = 1'b1; START = 1'($urandom); NBYTES = 2'($urandom); PC_IN = 16'($urandom);
    @(posedge CLK); #1;
    check("done_fall", {31'h0, DONE}, 32'h0);
    check("busy_fall", {31'h0, BUSY}, 32'h0);
    check("rd_idle", {31'h0, RD}, 32'h0);
    check("operand_hold", {16'h0, OPERAND}, {16'h0, exp_op});
    check("pc_out_hold", {16'h0, PC_OUT}, {16'h0, exp_pc});
    if (n_eff > 0) check("addr_hold", {16'h0, ADDR}, {16'h0, pc + 16'(n_eff - 1)});
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset is honoured even with CE low.
    RST = 1'b1; CE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset");
    @(negedge CLK);
    RST = 1'b0;

    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    run_fetch(16'h1234, 2'd2, 1'b0);

    mem[16'h00FF] = 8'h5A; mem[16'h0100] = 8'h99;
    run_fetch(16'h00FF, 2'd1, 1'b0);

    mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
    run_fetch(16'hFFFF, 2'd2, 1'b0);

    run_fetch(16'h4321, 2'd0, 1'b0);

    run_fetch(16'h1234, 2'd2, 1'b1);

    run_fetch(16'h2000, 2'd3, 1'b0);

    // Reset while the high byte is being fetched.
    mem[16'h4000] = 8'h77; mem[16'h4001] = 8'hEE;
    @(negedge CLK);
    CE = 1'b1; START = 1'b1; NBYTES = 2'd2; PC_IN = 16'h4000;
    @(posedge CLK); #1;
    @(negedge CLK);
    START = 1'b0;
    @(posedge CLK); #1;
    check("rd_hi_addr", {16'h0, ADDR}, 32'h4001);
    @(negedge CLK);
    RST = 1'b1; CE = 1'b0;
    @(posedge CLK); #1;
    check_reset_state("mid_reset");
    @(negedge CLK);
    RST = 1'b0; CE = 1'b1;
    run_fetch(16'h4000, 2'd1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_fetch(16'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
